// File: rtl/pipe_pkg.sv
// Shared pipeline types for the memory stage: data width, the memory-access
// FSM state encoding and the M/W pipeline register bundle.
package pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic            regwrite;
        logic            resultsrc;
        logic [4:0]      rd;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic            memerr;
    } mw_bundle_t;

endpackage

// File: rtl/memory_cycle_mc_if.sv
// Data-memory req/ack bus. The M stage is the master, the memory the slave.
interface memory_cycle_mc_if;
    import pipe_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/memory_cycle_mc_mw_pipe_reg.sv
// M/W pipeline register. Clear wins over bubble, bubble wins over load.
// A bubble only kills the write-enable so the rest of the bundle (and the
// forwarding view of it) stays exactly as it was.
module mw_pipe_reg
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       load_en,
    input  logic       bubble,
    input  mw_bundle_t d,
    output mw_bundle_t q
);

    mw_bundle_t q_q;

    // register update: clear / bubble / capture
    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else if (bubble) begin
            q_q.regwrite <= 1'b0;
        end else if (load_en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/memory_cycle_mc.sv
// Memory stage of the 5-stage pipeline: issues loads/stores on a req/ack bus,
// stalls upstream while an access is outstanding and owns the M/W register.
// Optional MEM_TIMEOUT_EN: watchdog aborts a WAIT that lasts TIMEOUT_CYCLES
// cycles and flags the instruction with MemErrW.
module memory_cycle_mc
    import pipe_pkg::*;
#(
    parameter int XLEN           = pipe_pkg::XLEN,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic            ResultSrcM,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] ALU_ResultM,
    memory_cycle_mc_if.master dmem,
    output logic            StallM,
    output logic            RegWriteW,
    output logic            ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] ResultW,
    output logic            MemErrW
);

    mem_state_t state_q;
    mw_bundle_t mw_d, mw_q;
    logic       access, is_load, in_wait, req, ack_hit, timeout;

    assign is_load = ResultSrcM & RegWriteM;
    assign access  = MemWriteM | is_load;
    assign in_wait = (state_q == MEM_WAIT);
    // Reset masks the request so nothing escapes while the pipe is flushed.
    assign req     = (access | in_wait) & ~rst;
    assign ack_hit = req & dmem.dmem_ack;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q;

    assign timeout = in_wait & ~dmem.dmem_ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // watchdog: held at 0 outside WAIT, counts WAIT cycles
    always_ff @(posedge clk) begin
        if (rst || !in_wait) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
`endif

    // access FSM: IDLE issues, WAIT holds until ack (or watchdog abort)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
        end else begin
            case (state_q)
                MEM_IDLE: if (access && !dmem.dmem_ack) state_q <= MEM_WAIT;
                MEM_WAIT: if (dmem.dmem_ack || timeout) state_q <= MEM_IDLE;
                default:  state_q <= MEM_IDLE;
            endcase
        end
    end

    // bus drive comes straight from the (frozen) M inputs
    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & MemWriteM;
    assign dmem.dmem_addr  = ALU_ResultM;
    assign dmem.dmem_wdata = WriteDataM;

    // An aborted access is not a stall: it retires with the error flag set.
    assign StallM = req & ~ack_hit & ~timeout;

    // next M/W contents; ReadDataW only moves on a completed load
    always_comb begin
        mw_d            = '0;
        mw_d.regwrite   = RegWriteM & ~timeout;
        mw_d.resultsrc  = ResultSrcM;
        mw_d.rd         = RD_M;
        mw_d.pcplus4    = PCPlus4M;
        mw_d.alu_result = ALU_ResultM;
        mw_d.read_data  = (ack_hit & is_load) ? dmem.dmem_rdata : mw_q.read_data;
        mw_d.memerr     = timeout;
    end

    mw_pipe_reg u_mw (
        .clk     (clk),
        .clr     (rst),
        .load_en (~StallM),
        .bubble  (StallM),
        .d       (mw_d),
        .q       (mw_q)
    );

    assign RegWriteW   = mw_q.regwrite;
    assign ResultSrcW  = mw_q.resultsrc;
    assign RD_W        = mw_q.rd;
    assign PCPlus4W    = mw_q.pcplus4;
    assign ALU_ResultW = mw_q.alu_result;
    assign ReadDataW   = mw_q.read_data;
    assign MemErrW     = mw_q.memerr;
    assign ResultW     = mw_q.resultsrc ? mw_q.read_data : mw_q.alu_result;

endmodule

// File: tb/tb_memory_cycle_mc.sv
// Directed bench for memory_cycle_mc: a table of single-cycle vectors plus
// hand-written multi-cycle sequences (wait states, reset in WAIT, watchdog).
module tb_memory_cycle_mc;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        StallM, RegWriteW, ResultSrcW, MemErrW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;

    int n_cmp = 0;
    int n_err = 0;

    memory_cycle_mc_if bus ();

    memory_cycle_mc #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .WriteDataM  (WriteDataM),
        .ALU_ResultM (ALU_ResultM),
        .dmem        (bus.master),
        .StallM      (StallM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .ResultW     (ResultW),
        .MemErrW     (MemErrW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mw, rs;
        logic [4:0]  rd;
        logic [31:0] alu, wd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_we, e_stall, e_rww;
        logic [4:0]  e_rdw;
        logic [31:0] e_res, e_rddata;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        PCPlus4M    = pc;
        WriteDataM  = wd;
        ALU_ResultM = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nreq, nstall;

        //            rw    mw    rs    rd     alu            wd            ack   rdata          req   we    stl   rww   rdw    res            rddata
        tv[0] = '{1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_002A, 32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_002A, 32'h0};
        tv[1] = '{1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0100, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tv[2] = '{1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0099, 32'h0,        1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0099, 32'hDEAD_BEEF};
        tv[3] = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0300, 32'h0000_ABCD, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0300, 32'hDEAD_BEEF};
        tv[4] = '{1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0104, 32'h0,        1'b1, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1111_2222, 32'h1111_2222};
        tv[5] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         32'h1111_2222};

        // reset held 2 cycles with a load and ack presented
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h4, 32'h0, 32'h100);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("rst_stall", {31'b0, StallM}, 32'd0);
        tick();
        tick();
        chk("rst_rww", {31'b0, RegWriteW}, 32'd0);
        chk("rst_rdw", {27'b0, RD_W}, 32'd0);
        chk("rst_resw", ResultW, 32'd0);
        chk("rst_rddata", ReadDataW, 32'd0);
        chk("rst_pc4w", PCPlus4W, 32'd0);
        chk("rst_memerr", {31'b0, MemErrW}, 32'd0);
        chk("rst_req2", {31'b0, bus.dmem_req}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        bus.dmem_ack = 1'b0;
        tick();

        // single-cycle vectors
        for (int i = 0; i < 6; i++) begin
            drive(tv[i].rw, tv[i].mw, tv[i].rs, tv[i].rd, 32'h400 + 32'(i * 4), tv[i].wd, tv[i].alu);
            bus.dmem_ack   = tv[i].ack;
            bus.dmem_rdata = tv[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, bus.dmem_req}, {31'b0, tv[i].e_req});
            chk($sformatf("v%0d_stall", i), {31'b0, StallM}, {31'b0, tv[i].e_stall});
            if (tv[i].e_req) begin
                chk($sformatf("v%0d_we", i), {31'b0, bus.dmem_we}, {31'b0, tv[i].e_we});
                chk($sformatf("v%0d_addr", i), bus.dmem_addr, tv[i].alu);
            end
            tick();
            chk($sformatf("v%0d_rww", i), {31'b0, RegWriteW}, {31'b0, tv[i].e_rww});
            chk($sformatf("v%0d_rdw", i), {27'b0, RD_W}, {27'b0, tv[i].e_rdw});
            chk($sformatf("v%0d_resw", i), ResultW, tv[i].e_res);
            chk($sformatf("v%0d_rddata", i), ReadDataW, tv[i].e_rddata);
            chk($sformatf("v%0d_pc4w", i), PCPlus4W, 32'h400 + 32'(i * 4));
            chk($sformatf("v%0d_memerr", i), {31'b0, MemErrW}, 32'd0);
        end
        bus.dmem_ack = 1'b0;

        // store with ack 3 cycles after request, bubbles in between
        drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h500, 32'h0, 32'h77);
        tick();
        chk("pre_rww", {31'b0, RegWriteW}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 5'd2, 32'h504, 32'h1234, 32'h200);
        nreq = 0;
        nstall = 0;
        for (int c = 0; c < 4; c++) begin
            bus.dmem_ack = (c == 3);
            #1;
            if (bus.dmem_req && bus.dmem_we) nreq++;
            if (StallM) nstall++;
            chk($sformatf("st_addr%0d", c), bus.dmem_addr, 32'h200);
            chk($sformatf("st_wdata%0d", c), bus.dmem_wdata, 32'h1234);
            tick();
            if (c < 3) begin
                chk($sformatf("st_bub_rww%0d", c), {31'b0, RegWriteW}, 32'd0);
                chk($sformatf("st_bub_rdw%0d", c), {27'b0, RD_W}, 32'd9);
            end
        end
        chk("st_req_cycles", nreq, 32'd4);
        chk("st_stall_cycles", nstall, 32'd3);
        chk("st_rww", {31'b0, RegWriteW}, 32'd0);
        chk("st_rdw", {27'b0, RD_W}, 32'd2);
        chk("st_resw", ResultW, 32'h200);

        // back-to-back zero-wait load right after the ack
        drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h508, 32'h0, 32'h210);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hCAFE_F00D;
        #1;
        chk("b2b_req", {31'b0, bus.dmem_req}, 32'd1);
        chk("b2b_stall", {31'b0, StallM}, 32'd0);
        tick();
        chk("b2b_resw", ResultW, 32'hCAFE_F00D);
        chk("b2b_rww", {31'b0, RegWriteW}, 32'd1);
        bus.dmem_ack = 1'b0;

        // load waiting for ack, reset in the 2nd WAIT cycle, late ack ignored
        drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h50C, 32'h0, 32'h300);
        #1;
        chk("rw_stall0", {31'b0, StallM}, 32'd1);
        tick();
        chk("rw_stall1", {31'b0, StallM}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("rw_clr_rddata", ReadDataW, 32'd0);
        chk("rw_clr_rww", {31'b0, RegWriteW}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("late_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("late_stall", {31'b0, StallM}, 32'd0);
        tick();
        chk("late_rddata", ReadDataW, 32'd0);
        chk("late_rww", {31'b0, RegWriteW}, 32'd0);
        bus.dmem_ack = 1'b0;
        #1;
        chk("late_stall2", {31'b0, StallM}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // load never acked: 1 issue cycle + 4 WAIT cycles, abort in the last
        drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h510, 32'h0, 32'h400);
        #1;
        chk("to_stall_issue", {31'b0, StallM}, 32'd1);
        tick();
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("to_stall_w%0d", w), {31'b0, StallM}, (w < 3) ? 32'd1 : 32'd0);
            chk($sformatf("to_req_w%0d", w), {31'b0, bus.dmem_req}, 32'd1);
            tick();
        end
        chk("to_memerr", {31'b0, MemErrW}, 32'd1);
        chk("to_rww", {31'b0, RegWriteW}, 32'd0);
        chk("to_rdw", {27'b0, RD_W}, 32'd8);
        drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h514, 32'h0, 32'h5);
        #1;
        chk("to_idle_stall", {31'b0, StallM}, 32'd0);
        tick();
        chk("to_memerr_clr", {31'b0, MemErrW}, 32'd0);
        chk("to_next_rww", {31'b0, RegWriteW}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
